// File: rtl/booth_mul_arbiter.sv
// booth_mul_arbiter: round-robin front end that shares one Booth multiplier
// among N_REQ requesters. It grants one request, latches that requester's
// operands, pulses the multiplier start, waits for the rising edge of done
// (or a timeout), and returns the product with a one-cycle ack.
module booth_mul_arbiter #(
    parameter int N_REQ   = 4,
    parameter int W       = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*W-1:0]         a_bus,
    input  logic [N_REQ*W-1:0]         b_bus,
    output logic [N_REQ-1:0]           ack,
    output logic [2*W-1:0]             result,
    output logic [$clog2(N_REQ)-1:0]   result_id,
    output logic                       err,
    output logic                       busy,
    output logic [W-1:0]               mul_a,
    output logic [W-1:0]               mul_b,
    output logic                       mul_start,
    input  logic                       mul_done,
    input  logic [2*W-1:0]             mul_result
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   gnt_id_q, gnt_id_d;
    logic [W-1:0]    mul_a_q, mul_a_d;
    logic [W-1:0]    mul_b_q, mul_b_d;
    logic [2*W-1:0]  result_q, result_d;
    logic [IW-1:0]   result_id_q, result_id_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_flag_q, err_flag_d;
    logic            done_q;

    logic            pick_found;
    logic [IW-1:0]   pick_id;
    int              scan_idx;
    logic            completion;

    // Round-robin scan: first asserted request starting at rr_ptr, wrapping.
    always_comb begin
        // NOTE: every combinational output gets a default first so that no
        // path leaves it unassigned, which would otherwise infer a latch.
        pick_found = 1'b0;
        pick_id    = rr_ptr_q;
        scan_idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_idx = (int'(rr_ptr_q) + k) % N_REQ;
            if (!pick_found && req[scan_idx]) begin
                pick_found = 1'b1;
                pick_id    = IW'(scan_idx);
            end
        end
    end

    // A stale done level at START is not a completion; only a 0->1 edge counts.
    assign completion = mul_done & ~done_q;

    // Next-state and datapath register updates for the sequencer FSM.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_id_d    = gnt_id_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        result_d    = result_q;
        result_id_d = result_id_q;
        cnt_d       = cnt_q;
        err_flag_d  = err_flag_q;

        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    gnt_id_d = pick_id;
                    mul_a_d  = a_bus[int'(pick_id)*W +: W];
                    mul_b_d  = b_bus[int'(pick_id)*W +: W];
                    state_d  = START;
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (completion) begin
                    result_d    = mul_result;
                    result_id_d = gnt_id_q;
                    state_d     = RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    result_d    = '0;
                    result_id_d = gnt_id_q;
                    err_flag_d  = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                rr_ptr_d   = (gnt_id_q == IW'(N_REQ - 1)) ? '0 : gnt_id_q + 1'b1;
                err_flag_d = 1'b0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset mid-operation drops back to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            gnt_id_q    <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            result_q    <= '0;
            result_id_q <= '0;
            cnt_q       <= '0;
            err_flag_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_id_q    <= gnt_id_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            result_q    <= result_d;
            result_id_q <= result_id_d;
            cnt_q       <= cnt_d;
            err_flag_q  <= err_flag_d;
            done_q      <= mul_done;
        end
    end

    // Strobes decoded from state so they vanish the instant reset hits.
    always_comb begin
        ack = '0;
        if (state_q == RESP) begin
            ack[gnt_id_q] = 1'b1;
        end
    end

    assign err       = (state_q == RESP) & err_flag_q;
    assign mul_start = (state_q == START);
    assign busy      = (state_q != IDLE);
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign result    = result_q;
    assign result_id = result_id_q;

endmodule
